// File: rtl/fighting_pkg.sv
// fighting_pkg: XADC joystick channel addresses, step constants and FSM encoding.
package fighting_pkg;
  localparam logic [6:0] ADDR_AUX6 = 7'h16;
  localparam logic [6:0] ADDR_AUX14 = 7'h1E;
  localparam logic [6:0] ADDR_AUX7 = 7'h17;
  localparam logic [6:0] ADDR_AUX15 = 7'h1F;
  localparam logic signed [10:0] STEP_POS = 11'sd1;
  localparam logic signed [10:0] STEP_NEG = -11'sd1;
  localparam logic signed [10:0] STEP_ZERO = 11'sd0;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, NEXT} state_t;
  typedef enum logic [1:0] {NEUTRAL, HIGH, LOW} level_t;
  function automatic logic [6:0] chan_addr(input logic [1:0] i);
    return i == 2'd0 ? ADDR_AUX6 : i == 2'd1 ? ADDR_AUX14 : i == 2'd2 ? ADDR_AUX7 : ADDR_AUX15;
  endfunction
  function automatic logic signed [10:0] x_step(input level_t l);
    return l == HIGH ? STEP_POS : l == LOW ? STEP_NEG : STEP_ZERO;
  endfunction
endpackage

// File: rtl/axis_decode.sv
// axis_decode: classifies a 12-bit ADC code as HIGH, LOW or NEUTRAL around CENTER.
module axis_decode
  import fighting_pkg::*;
#(
  parameter logic [11:0] CENTER = 12'h800,
  parameter logic [11:0] DEADBAND = 12'h200
) (
  input  logic [11:0] v,
  output level_t      lvl
);
  localparam logic [12:0] HI = {1'b0, CENTER} + {1'b0, DEADBAND};
  localparam logic [12:0] LO = {1'b0, CENTER} - {1'b0, DEADBAND};
  always_comb lvl = {1'b0, v} > HI ? HIGH : {1'b0, v} < LO ? LOW : NEUTRAL;
endmodule

// File: rtl/xadc_joy_reader.sv
// xadc_joy_reader: polls four XADC aux channels over DRP and commits decoded joystick commands.
module xadc_joy_reader
  import fighting_pkg::*;
#(
  parameter int          SAMPLE_DIV = 1_666_667,
  parameter int          TIMEOUT = 255,
  parameter logic [11:0] CENTER = 12'h800,
  parameter logic [11:0] DEADBAND = 12'h200
) (
  input  logic                clk,
  input  logic                rst,
  output logic [6:0]          drp_daddr,
  output logic                drp_den,
  input  logic [15:0]         drp_do,
  input  logic                drp_drdy,
  output logic signed [10:0]  p1_dx,
  output logic signed [10:0]  p1_dy,
  output logic                p1_kick,
  output logic signed [10:0]  p2_dx,
  output logic signed [10:0]  p2_dy,
  output logic                p2_kick,
  output logic                sample_valid,
  output logic                timeout_err
);
  localparam int DW = $clog2(SAMPLE_DIV);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state, nxt;
  logic [DW-1:0] div_cnt;
  logic [TW-1:0] wait_cnt;
  logic [1:0] idx;
  logic [11:0] shadow [4];
  level_t lvl [4];
  logic tick, got, expired, commit, unused_lsb;
  assign unused_lsb = ^drp_do[3:0];
  assign tick = div_cnt == DW'(SAMPLE_DIV - 1);
  assign got = state == WAIT && drp_drdy;
  assign expired = state == WAIT && !drp_drdy && wait_cnt == TW'(TIMEOUT - 1);
  assign commit = state == NEXT && idx == 2'd3;
  assign drp_daddr = chan_addr(idx);
  genvar i;
  for (i = 0; i < 4; i++) begin : g_dec
    axis_decode #(.CENTER(CENTER), .DEADBAND(DEADBAND)) u_dec (.v(shadow[i]), .lvl(lvl[i]));
  end
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (tick ? ISSUE : IDLE) :
          state == ISSUE ? WAIT :
          state == WAIT ? (got || expired ? NEXT : WAIT) :
          idx == 2'd3 ? IDLE : ISSUE;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      wait_cnt <= '0;
      idx <= '0;
      drp_den <= 1'b0;
      shadow <= '{default: CENTER};
      p1_dx <= STEP_ZERO;
      p1_dy <= STEP_ZERO;
      p1_kick <= 1'b0;
      p2_dx <= STEP_ZERO;
      p2_dy <= STEP_ZERO;
      p2_kick <= 1'b0;
      sample_valid <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      wait_cnt <= state == WAIT ? wait_cnt + 1'b1 : '0;
      idx <= state == NEXT ? idx + 1'b1 : state == IDLE ? 2'd0 : idx;
      drp_den <= nxt == ISSUE;
      sample_valid <= commit;
      timeout_err <= timeout_err | expired;
      if (got) shadow[idx] <= drp_do[15:4];
      // all six commands switch together so the game never sees a mixed set
      if (commit) begin
        p1_dx <= x_step(lvl[0]);
        p1_dy <= lvl[1] == HIGH ? STEP_POS : STEP_ZERO;
        p1_kick <= lvl[1] == LOW;
        p2_dx <= x_step(lvl[2]);
        p2_dy <= lvl[3] == HIGH ? STEP_POS : STEP_ZERO;
        p2_kick <= lvl[3] == LOW;
      end
    end
  end
endmodule

// File: tb/tb_xadc_joy_reader.sv
// tb_xadc_joy_reader: randomized DRP responder with a scoreboard of expected command sets.
module tb_xadc_joy_reader;
  localparam int TO = 255;
  localparam int C = 'h800;
  localparam int D = 'h200;
  typedef struct packed {
    logic [3:0][11:0] v;
    logic [3:0][9:0]  lat;
    logic             tag;
  } round_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] drp_daddr;
  logic drp_den;
  logic [15:0] drp_do = '0;
  logic drp_drdy = 1'b0;
  logic signed [10:0] p1_dx, p1_dy, p2_dx, p2_dy;
  logic p1_kick, p2_kick, sample_valid, timeout_err;
  logic [46:0] outv, last;
  round_t stim_q[$];
  logic [46:0] exp_q[$];
  round_t cur;
  int m_sh[4];
  bit m_err, in_stim, pend;
  int ridx, cnt, n_cmp, n_bad;
  logic [11:0] pend_v;
  always #5 clk = ~clk;
  xadc_joy_reader #(.SAMPLE_DIV(8), .TIMEOUT(TO), .CENTER(12'h800), .DEADBAND(12'h200)) dut (
    .clk(clk), .rst(rst), .drp_daddr(drp_daddr), .drp_den(drp_den), .drp_do(drp_do),
    .drp_drdy(drp_drdy), .p1_dx(p1_dx), .p1_dy(p1_dy), .p1_kick(p1_kick), .p2_dx(p2_dx),
    .p2_dy(p2_dy), .p2_kick(p2_kick), .sample_valid(sample_valid), .timeout_err(timeout_err)
  );
  assign outv = {p1_dx, p1_dy, p1_kick, p2_dx, p2_dy, p2_kick, timeout_err};
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [6:0] addr_of(input int i);
    case (i)
      0: return 7'h16;
      1: return 7'h1E;
      2: return 7'h17;
      default: return 7'h1F;
    endcase
  endfunction
  function automatic logic [10:0] xs(input int v);
    return v > C + D ? 11'd1 : v < C - D ? 11'h7FF : 11'd0;
  endfunction
  function automatic logic [10:0] ys(input int v);
    return v > C + D ? 11'd1 : 11'd0;
  endfunction
  function automatic logic [46:0] model_vec();
    return {xs(m_sh[0]), ys(m_sh[1]), 1'(m_sh[1] < C - D), xs(m_sh[2]), ys(m_sh[3]), 1'(m_sh[3] < C - D), m_err};
  endfunction
  function automatic round_t mk(input logic [11:0] a, b, c, d, input int l);
    round_t r;
    r.v = {d, c, b, a};
    r.lat = {4{10'(l)}};
    r.tag = 1'b0;
    return r;
  endfunction
  function automatic round_t rnd_round();
    round_t r;
    for (int k = 0; k < 4; k++) begin
      r.v[k] = 12'($urandom);
      r.lat[k] = 10'($urandom_range(1, 6));
    end
    r.tag = 1'b0;
    return r;
  endfunction
  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_sh[k] = C;
    m_err = 0;
    ridx = 0;
    in_stim = 0;
    exp_q.delete();
    stim_q.delete();
  endtask
  task automatic drain();
    int i;
    for (i = 0; i < 5000 && (stim_q.size() != 0 || in_stim || exp_q.size() != 0); i++) @(negedge clk);
    chk("drain_budget", 64'(stim_q.size() + exp_q.size() + int'(in_stim)), 0);
  endtask
  task automatic check_reset_values();
    chk("rst_outputs", 64'(outv), 0);
    chk("rst_den", 64'(drp_den), 0);
    chk("rst_daddr", 64'(drp_daddr), 64'h16);
    chk("rst_sample_valid", 64'(sample_valid), 0);
  endtask
  // DRP responder: answers each strobe after the round's chosen latency, or never if it exceeds TIMEOUT
  always @(negedge clk) begin
    drp_drdy = 1'b0;
    drp_do = 16'($urandom);
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        pend = 0;
        drp_drdy = 1'b1;
        drp_do = {pend_v, 4'($urandom)};
      end
    end
    if (drp_den && !rst) begin
      chk("one_outstanding", 64'(pend), 0);
      chk("daddr", 64'(drp_daddr), 64'(addr_of(ridx)));
      if (ridx == 0) begin
        if (stim_q.size() != 0) begin
          cur = stim_q.pop_front();
          in_stim = 1;
        end else cur = rnd_round();
      end
      if (int'(cur.lat[ridx]) > TO) m_err = 1;
      else begin
        pend = 1;
        cnt = int'(cur.lat[ridx]);
        pend_v = cur.v[ridx];
        m_sh[ridx] = int'(cur.v[ridx]);
      end
      if (ridx == 3) begin
        exp_q.push_back(model_vec());
        in_stim = 0;
      end
      ridx = (ridx + 1) % 4;
    end
  end
  always @(negedge clk) begin
    if (rst) last = '0;
    else if (sample_valid) begin
      chk("sample_expected", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("commit", 64'(outv), 64'(exp_q.pop_front()));
      last = outv;
    end else chk("hold_between_commits", 64'(outv[46:1]), 64'(last[46:1]));
  end
  initial begin
    round_t r;
    int i;
    n_cmp = 0;
    n_bad = 0;
    pend = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values();
    chk("rst_timeout_err", 64'(timeout_err), 0);
    rst = 1'b0;
    stim_q.push_back(mk(12'hF00, 12'h800, 12'h100, 12'h100, 3));
    stim_q.push_back(mk(12'hA00, 12'($urandom), 12'($urandom), 12'($urandom), 2));
    stim_q.push_back(mk(12'h600, 12'($urandom), 12'($urandom), 12'($urandom), 2));
    stim_q.push_back(mk(12'hA01, 12'($urandom), 12'($urandom), 12'($urandom), 2));
    stim_q.push_back(mk(12'h5FF, 12'($urandom), 12'($urandom), 12'($urandom), 2));
    r = mk(12'($urandom), 12'($urandom), 12'($urandom), 12'hC00, 2);
    r.lat[3] = 10'(TO);
    stim_q.push_back(r);
    drain();
    chk("coincident_no_err", 64'(timeout_err), 0);
    for (int k = 0; k < 20; k++) stim_q.push_back(rnd_round());
    drain();
    r = mk(12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom), 2);
    r.lat[2] = 10'(300);
    stim_q.push_back(r);
    drain();
    chk("timeout_sticky", 64'(timeout_err), 1);
    r = mk(12'($urandom), 12'hF00, 12'($urandom), 12'($urandom), 2);
    r.lat[1] = 10'd12;
    r.tag = 1'b1;
    stim_q.push_back(r);
    for (i = 0; i < 3000 && !(drp_den && drp_daddr == 7'h1E && cur.tag); i++) @(negedge clk);
    chk("reached_wait_1e", 64'(i < 3000), 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values();
    chk("rst_clears_err", 64'(timeout_err), 0);
    rst = 1'b0;
    r = mk(12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom), 2);
    r.lat[1] = 10'(300);
    stim_q.push_back(r);
    for (int k = 0; k < 5; k++) stim_q.push_back(rnd_round());
    drain();
    for (int k = 0; k < 3; k++) stim_q.push_back(mk(12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom), 20));
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
